// File: rtl/scroll_engine.sv
// Text-screen region scroller: copies rows up/down inside [top,bottom] through a
// 1-cycle-latency text RAM, then blanks the vacated rows. Macro SCROLL_PENDING_EN adds a one-entry request slot.
module scroll_engine #(
    parameter int LINES   = 50,
    parameter int COLUMNS = 80,
    parameter int ADDR_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_dir,
    input  logic [7:0]        req_step,
    input  logic [7:0]        req_top,
    input  logic [7:0]        req_bottom,
    input  logic              req_clear,
    input  logic [7:0]        fill_attr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              drop
);
    // state | meaning
    // IDLE  | waiting for a request
    // COPY  | one read per cycle, write of that cell on the following cycle
    // FILL  | one blank cell written per cycle
    // DONE  | completion pulse; may launch the pending request directly
    typedef enum logic [1:0] {IDLE, COPY, FILL, DONE} state_t;

    localparam logic [ADDR_W-1:0] COLS     = ADDR_W'(COLUMNS);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(COLUMNS - 1);
    localparam logic [ADDR_W-1:0] ROW_BACK = ADDR_W'(2 * COLUMNS - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [8:0]        LINES9   = 9'(LINES);

    state_t            state;
    logic              dir_q, wr_copy;
    logic [ADDR_W-1:0] dst_addr, fill_base, rd_cnt, fill_cnt, col_left;
    logic [15:0]       fill_word;

    logic              in_req, use_pend, launch, l_bad, l_dir, l_clear;
    logic [7:0]        l_step, l_top, l_bottom, l_attr;
    logic [8:0]        step9, h, s;
    logic [ADDR_W-1:0] src_start, dst_start, fill_start, copy_cells, fill_cells;

`ifdef SCROLL_PENDING_EN
    logic       pend_valid, pend_dir, pend_clear;
    logic [7:0] pend_step, pend_top, pend_bottom, pend_attr;
`endif

    // Launch source is the pending slot when it holds something, else the live inputs.
    always_comb begin
        in_req   = req_valid | req_clear;
        use_pend = 1'b0;
        l_dir    = req_dir;
        l_step   = req_step;
        l_top    = req_top;
        l_bottom = req_bottom;
        l_clear  = req_clear;
        l_attr   = fill_attr;
`ifdef SCROLL_PENDING_EN
        if (pend_valid && (state == IDLE || state == DONE)) begin
            use_pend = 1'b1;
            l_dir    = pend_dir;
            l_step   = pend_step;
            l_top    = pend_top;
            l_bottom = pend_bottom;
            l_clear  = pend_clear;
            l_attr   = pend_attr;
        end
`endif
        launch = (state == IDLE && in_req) || use_pend;
        l_bad  = !l_clear && ((l_top > l_bottom) || ({1'b0, l_bottom} >= LINES9));
        step9  = (l_step == 8'd0) ? 9'd1 : {1'b0, l_step};
        h      = {1'b0, l_bottom} - {1'b0, l_top} + 9'd1;
        s      = (step9 > h) ? h : step9;
        if (l_clear) begin
            h = LINES9;
            s = LINES9;
        end
        if (l_dir) begin
            src_start  = ADDR_W'({1'b0, l_bottom} - s) * COLS;
            dst_start  = ADDR_W'(l_bottom) * COLS;
            fill_start = ADDR_W'(l_top) * COLS;
        end else begin
            src_start  = ADDR_W'({1'b0, l_top} + s) * COLS;
            dst_start  = ADDR_W'(l_top) * COLS;
            fill_start = ADDR_W'({1'b0, l_bottom} - s + 9'd1) * COLS;
        end
        if (l_clear) fill_start = '0;
        copy_cells = ADDR_W'(h - s) * COLS;
        fill_cells = ADDR_W'(s) * COLS;
    end

    // Copy writes forward the RAM read data straight through; fill writes use the latched blank word.
    assign wr_data = !wr_en ? 16'h0 : (wr_copy ? rd_data : fill_word);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            drop      <= 1'b0;
            wr_en     <= 1'b0;
            wr_copy   <= 1'b0;
            rd_addr   <= '0;
            wr_addr   <= '0;
            dir_q     <= 1'b0;
            dst_addr  <= '0;
            fill_base <= '0;
            rd_cnt    <= '0;
            fill_cnt  <= '0;
            col_left  <= '0;
            fill_word <= '0;
`ifdef SCROLL_PENDING_EN
            pend_valid  <= 1'b0;
            pend_dir    <= 1'b0;
            pend_clear  <= 1'b0;
            pend_step   <= '0;
            pend_top    <= '0;
            pend_bottom <= '0;
            pend_attr   <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            drop <= 1'b0;
            if (launch) begin
                if (l_bad) begin
                    err   <= 1'b1;
                    state <= IDLE;
                    busy  <= 1'b0;
                    wr_en <= 1'b0;
                end else begin
                    busy      <= 1'b1;
                    dir_q     <= l_dir;
                    rd_addr   <= src_start;
                    dst_addr  <= dst_start;
                    rd_cnt    <= copy_cells;
                    col_left  <= COL_LAST;
                    fill_base <= fill_start;
                    fill_cnt  <= fill_cells - ONE;
                    fill_word <= {l_attr, 8'h20};
                    wr_copy   <= 1'b0;
                    if (copy_cells != '0) begin
                        state <= COPY;
                        wr_en <= 1'b0;
                    end else begin
                        state   <= FILL;
                        wr_en   <= 1'b1;
                        wr_addr <= fill_start;
                    end
                end
            end else begin
                case (state)
                    IDLE: ;
                    COPY: begin
                        if (rd_cnt != '0) begin
                            wr_en   <= 1'b1;
                            wr_copy <= 1'b1;
                            wr_addr <= dst_addr;
                            rd_cnt  <= rd_cnt - ONE;
                            if (col_left == '0) begin
                                col_left <= COL_LAST;
                                // Scrolling down walks rows backwards but columns forwards.
                                rd_addr  <= dir_q ? rd_addr - ROW_BACK : rd_addr + ONE;
                                dst_addr <= dir_q ? dst_addr - ROW_BACK : dst_addr + ONE;
                            end else begin
                                col_left <= col_left - ONE;
                                rd_addr  <= rd_addr + ONE;
                                dst_addr <= dst_addr + ONE;
                            end
                        end else begin
                            state   <= FILL;
                            wr_en   <= 1'b1;
                            wr_copy <= 1'b0;
                            wr_addr <= fill_base;
                        end
                    end
                    FILL: begin
                        if (fill_cnt != '0) begin
                            wr_addr  <= wr_addr + ONE;
                            fill_cnt <= fill_cnt - ONE;
                        end else begin
                            state <= DONE;
                            wr_en <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
`ifdef SCROLL_PENDING_EN
            if (use_pend) pend_valid <= 1'b0;
            if (in_req && (state != IDLE || use_pend)) begin
                pend_valid  <= 1'b1;
                pend_dir    <= req_dir;
                pend_clear  <= req_clear;
                pend_step   <= req_step;
                pend_top    <= req_top;
                pend_bottom <= req_bottom;
                pend_attr   <= fill_attr;
                if (pend_valid && !use_pend) drop <= 1'b1;
            end
`else
            if (in_req && state != IDLE) drop <= 1'b1;
`endif
        end
    end
endmodule
